// File: rtl/lsu_ctrl.sv
// Load/store unit: latches one EX-stage memory access, runs a req/ready
// transaction to the data RAM, and returns an aligned, extended load result.
module lsu_ctrl #(
   parameter int TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        es_valid,
   input  logic [5:0]  es_ctrl,
   input  logic [2:0]  es_funct3,
   input  logic [31:0] es_alu_result,
   input  logic [31:0] es_rs2_data,
   output logic        lsu_stall,
   output logic        lsu_exc,
   output logic        bus_err,
   output logic        dram_req,
   output logic        dram_we,
   output logic [31:0] dram_addr,
   output logic [31:0] dram_wdata,
   output logic [3:0]  dram_wstrb,
   input  logic        dram_ready,
   input  logic [31:0] dram_rdata,
   output logic [31:0] mem_out_data
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      off_q;
   logic [2:0]      f3_q;
   logic            req_q, we_q, berr_q;
   logic [31:0]     addr_q, wdata_q, rdata_q;
   logic [3:0]      wstrb_q;

   logic            mem_read, mem_write, mem_op, illegal, start;
   logic            load_f3_ok, store_f3_ok, misalign;
   logic [3:0]      wstrb_d;
   logic [31:0]     wdata_d;
   logic            unused_ctrl;

   assign mem_read    = es_ctrl[3];
   assign mem_write   = es_ctrl[2];
   assign unused_ctrl = ^{es_ctrl[5:4], es_ctrl[1:0]};
   assign mem_op      = es_valid & (mem_read | mem_write);

   function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [31:0] s;
      s = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  return {{24{s[7]}}, s[7:0]};
         3'b001:  return {{16{s[15]}}, s[15:0]};
         3'b100:  return {24'b0, s[7:0]};
         3'b101:  return {16'b0, s[15:0]};
         default: return rdata;
      endcase
   endfunction

   always_comb begin
      load_f3_ok  = 1'b0;
      store_f3_ok = 1'b0;
      case (es_funct3)
         3'b000, 3'b001, 3'b010: begin
            load_f3_ok  = 1'b1;
            store_f3_ok = 1'b1;
         end
         3'b100, 3'b101: load_f3_ok = 1'b1;
         default: ;
      endcase
      misalign = ((es_funct3[1:0] == 2'b01) & es_alu_result[0]) |
                 ((es_funct3[1:0] == 2'b10) & (es_alu_result[1:0] != 2'b00));
      illegal  = (mem_read & mem_write) | (mem_read & ~load_f3_ok) |
                 (mem_write & ~store_f3_ok) | misalign;
   end

   always_comb begin
      wstrb_d = 4'b0000;
      wdata_d = es_rs2_data;
      case (es_funct3[1:0])
         2'b00: begin
            wstrb_d = 4'b0001 << es_alu_result[1:0];
            wdata_d = {4{es_rs2_data[7:0]}};
         end
         2'b01: begin
            wstrb_d = 4'b0011 << {es_alu_result[1], 1'b0};
            wdata_d = {2{es_rs2_data[15:0]}};
         end
         default: wstrb_d = 4'b1111;
      endcase
      if (!mem_write) wstrb_d = 4'b0000;
   end

   assign start     = (state_q == IDLE) & mem_op & ~illegal;
   assign lsu_exc   = mem_op & illegal;
   assign lsu_stall = start | (state_q == BUSY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         off_q   <= 2'b00;
         f3_q    <= 3'b000;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         berr_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= 4'b0000;
         rdata_q <= '0;
      end else begin
         berr_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               state_q <= BUSY;
               req_q   <= 1'b1;
               we_q    <= mem_write;
               addr_q  <= {es_alu_result[31:2], 2'b00};
               wdata_q <= wdata_d;
               wstrb_q <= wstrb_d;
               off_q   <= es_alu_result[1:0];
               f3_q    <= es_funct3;
               cnt_q   <= '0;
            end
            BUSY: begin
               if (dram_ready) begin
                  state_q <= DONE;
                  req_q   <= 1'b0;
                  if (!we_q) rdata_q <= extend_load(dram_rdata, off_q, f3_q);
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  // Abort: the RAM never answered, so the load result is forced to zero.
                  state_q <= DONE;
                  req_q   <= 1'b0;
                  berr_q  <= 1'b1;
                  if (!we_q) rdata_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dram_req     = req_q;
   assign dram_we      = we_q;
   assign dram_addr    = addr_q;
   assign dram_wdata   = wdata_q;
   assign dram_wstrb   = wstrb_q;
   assign bus_err      = berr_q;
   assign mem_out_data = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed plus randomized bench for lsu_ctrl against an arithmetic reference model.
module tb_lsu_ctrl;

   localparam int TO = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        es_valid;
   logic [5:0]  es_ctrl;
   logic [2:0]  es_funct3;
   logic [31:0] es_alu_result, es_rs2_data;
   logic        lsu_stall, lsu_exc, bus_err;
   logic        dram_req, dram_we, dram_ready;
   logic [31:0] dram_addr, dram_wdata, dram_rdata, mem_out_data;
   logic [3:0]  dram_wstrb;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_mem;

   localparam logic [5:0] RD = 6'b001000;
   localparam logic [5:0] WR = 6'b000100;

   lsu_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .es_valid(es_valid), .es_ctrl(es_ctrl),
      .es_funct3(es_funct3), .es_alu_result(es_alu_result), .es_rs2_data(es_rs2_data),
      .lsu_stall(lsu_stall), .lsu_exc(lsu_exc), .bus_err(bus_err),
      .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
      .dram_wdata(dram_wdata), .dram_wstrb(dram_wstrb), .dram_ready(dram_ready),
      .dram_rdata(dram_rdata), .mem_out_data(mem_out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit m_illegal(input bit rd, input bit wr, input int unsigned f3,
                                    input int unsigned a);
      if (rd && wr) return 1;
      if (wr && f3 > 2) return 1;
      if (rd && !(f3 <= 2 || f3 == 4 || f3 == 5)) return 1;
      if ((f3 == 1 || f3 == 5) && (a % 2) != 0) return 1;
      if (f3 == 2 && (a % 4) != 0) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] m_load(input int unsigned rdata, input int unsigned a,
                                          input int unsigned f3);
      int unsigned sh, b, h;
      sh = rdata >> (8 * (a % 4));
      b  = sh % 256;
      h  = sh % 65536;
      case (f3)
         0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         4: return b;
         5: return h;
         default: return rdata;
      endcase
   endfunction

   function automatic logic [3:0] m_wstrb(input int unsigned a, input int unsigned f3);
      if (f3 == 0) return 4'(1 << (a % 4));
      if (f3 == 1) return 4'(3 << (a % 4));
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input int unsigned d, input int unsigned f3);
      if (f3 == 0) return (d % 256) * 32'h0101_0101;
      if (f3 == 1) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   // Called one time unit after a rising edge, with the DUT in IDLE.
   task automatic access(input logic v, input logic [5:0] ctrl, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int delay);
      bit rd, wr, op, ill, timed_out, done;
      int n, b;
      rd = ctrl[3];
      wr = ctrl[2];
      op = v && (rd || wr);
      ill = op && m_illegal(rd, wr, f3, a);
      timed_out = (delay >= TO);
      es_valid = v; es_ctrl = ctrl; es_funct3 = f3; es_alu_result = a; es_rs2_data = rs2;
      dram_ready = 1'b0;
      #1;
      check("lsu_exc", lsu_exc, ill);
      if (!op || ill) begin
         check("stall_noop", lsu_stall, 0);
         @(posedge clk); #1;
         check("req_noop", dram_req, 0);
         check("mem_hold_noop", mem_out_data, exp_mem);
         es_valid = 1'b0;
         return;
      end
      check("stall_idle", lsu_stall, 1);
      n = 1; b = 0; done = 0;
      for (int cyc = 0; cyc < 4 * TO + 10 && !done; cyc++) begin
         @(posedge clk); #1;
         if (lsu_stall) begin
            n++;
            check("req_busy", dram_req, 1);
            check("we_busy", dram_we, wr);
            check("addr_busy", dram_addr, a & 32'hFFFF_FFFC);
            if (wr) begin
               check("wstrb_busy", dram_wstrb, m_wstrb(a, f3));
               check("wdata_busy", dram_wdata, m_wdata(rs2, f3));
            end else begin
               check("wstrb_load", dram_wstrb, 0);
            end
            if (b == delay) begin
               dram_ready = 1'b1; dram_rdata = rdata;
            end else begin
               dram_ready = 1'b0; dram_rdata = $urandom;
            end
            b++;
         end else begin
            done = 1;
         end
      end
      check("done_reached", done, 1);
      dram_ready = 1'b0;
      if (!wr) exp_mem = timed_out ? 32'h0 : m_load(rdata, a, f3);
      check("stall_cycles", n, 1 + (timed_out ? TO : delay + 1));
      check("bus_err_done", bus_err, timed_out);
      check("req_done", dram_req, 0);
      check("mem_out_done", mem_out_data, exp_mem);
      es_valid = 1'b0;
      @(posedge clk); #1;
      check("bus_err_idle", bus_err, 0);
      check("stall_idle_after", lsu_stall, 0);
      check("mem_out_idle", mem_out_data, exp_mem);
   endtask

   initial begin
      logic [5:0] c;
      rst_n = 1'b0; es_valid = 1'b0; es_ctrl = '0; es_funct3 = '0;
      es_alu_result = '0; es_rs2_data = '0; dram_ready = 1'b0; dram_rdata = '0;
      exp_mem = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", dram_req, 0);
      check("rst_we", dram_we, 0);
      check("rst_addr", dram_addr, 0);
      check("rst_wdata", dram_wdata, 0);
      check("rst_wstrb", dram_wstrb, 0);
      check("rst_mem_out", mem_out_data, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_stall", lsu_stall, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      access(1, RD, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
      check("lb_result", mem_out_data, 32'hFFFF_FF80);
      access(1, RD, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 4);
      check("lhu_result", mem_out_data, 32'h0000_BEEF);
      access(1, WR, 3'b000, 32'h0000_3001, 32'h1234_56AB, 32'h0, 0);
      check("sb_hold", mem_out_data, 32'h0000_BEEF);
      access(1, RD, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0);
      access(1, WR, 3'b100, 32'h0000_4000, 32'h5555_AAAA, 32'h0, 0);
      access(1, RD | WR, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0);
      access(1, RD, 3'b010, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 100);
      check("timeout_result", mem_out_data, 32'h0);

      // Asynchronous reset during the second BUSY cycle.
      es_valid = 1'b1; es_ctrl = RD; es_funct3 = 3'b010; es_alu_result = 32'h0000_7000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_rst_req", dram_req, 1);
      rst_n = 1'b0; es_valid = 1'b0;
      #1;
      check("mid_rst_req", dram_req, 0);
      check("mid_rst_addr", dram_addr, 0);
      check("mid_rst_we", dram_we, 0);
      check("mid_rst_stall", lsu_stall, 0);
      check("mid_rst_mem", mem_out_data, 0);
      exp_mem = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      access(1, RD, 3'b010, 32'h0000_6004, 32'h0, 32'h1357_9BDF, 1);
      check("post_rst_lw", mem_out_data, 32'h1357_9BDF);

      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         case ($urandom_range(0, 5))
            0, 1, 2: c = RD;
            3, 4:    c = WR;
            default: c = ($urandom_range(0, 1) != 0) ? (RD | WR) : 6'b000000;
         endcase
         c = c | (6'($urandom) & 6'b110011);
         a = $urandom;
         if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
         access($urandom_range(0, 7) != 0, c, 3'($urandom), a, $urandom, $urandom,
                $urandom_range(0, TO + 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the execute stage and the memory stage.
- Takes the EX-stage address, store data and control, and runs a req/ready transaction to the data RAM.
- Aligns and sign- or zero-extends load data, then presents it as mem_out_data to the memory stage.
- Stalls the pipeline while a transaction is outstanding and flags misaligned or illegal accesses, as well as bus timeouts.

Parameters:
- TIMEOUT, 256: maximum cycles in BUSY waiting for dram_ready before the access is aborted with bus_err. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- es_valid  input  1  EX-stage instruction valid
- es_ctrl  input  6  EX control bundle; bit3 = mem_read, bit2 = mem_write; other bits ignored
- es_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- es_alu_result  input  32  effective byte address
- es_rs2_data  input  32  store data
- lsu_stall  output  1  hold IF/ID/EX and their pipeline registers
- lsu_exc  output  1  misaligned or illegal access (combinational)
- bus_err  output  1  one-cycle pulse on timeout
- dram_req  output  1  RAM request
- dram_we  output  1  1 = write
- dram_addr  output  32  word address, bits[1:0] = 0
- dram_wdata  output  32  lane-replicated store data
- dram_wstrb  output  4  byte enables
- dram_ready  input  1  RAM accepts/completes the request this cycle
- dram_rdata  input  32  read data, valid when dram_req & dram_ready & !dram_we
- mem_out_data  output  32  extended load result, registered

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values:
  - State is IDLE.
  - dram_req, dram_we, dram_wstrb, dram_addr, dram_wdata, mem_out_data, bus_err and the timeout counter are all 0.
  - Reset mid-transaction drops dram_req immediately; no completion is signalled.
- mem_op = es_valid & (mem_read | mem_write). If both bits are set, treat as illegal.
- Illegal access: misaligned (H with addr[0] = 1, W with addr[1:0] != 0), or funct3 not in the size list for the operation (stores allow 000/001/010 only).
- lsu_exc = mem_op & illegal. An illegal access never starts a transaction and never stalls.
- IDLE:
  - On mem_op & !illegal, register the access outputs and go to BUSY:
    - dram_addr = {addr[31:2], 2'b00}
    - dram_we = mem_write
    - dram_wstrb (store): B = 0001 << addr[1:0]; H = 0011 << {addr[1], 1'b0}; W = 1111. Loads: 0000.
    - dram_wdata: B = {4{rs2[7:0]}}, H = {2{rs2[15:0]}}, W = rs2.
  - Save the byte offset and funct3 internally.
  - Clear the timeout counter.
- BUSY:
  - dram_req = 1 and all request outputs are held stable.
  - On dram_ready: drop dram_req next cycle and go to DONE.
  - If the access is a read, capture mem_out_data in the same edge: select byte/half by the saved offset, then sign-extend (B/H) or zero-extend (BU/HU/W).
  - Without dram_ready: increment the counter. When it reaches TIMEOUT-1 with no ready, go to DONE, pulse bus_err for one cycle, and load mem_out_data = 0 if the access was a read.
- DONE: lasts one cycle with stall released so the pipeline advances; then return to IDLE.
- lsu_stall = (IDLE & mem_op & !illegal) | BUSY. It is 0 in DONE. Minimum latency is 3 cycles for a RAM that is ready on the first BUSY cycle.
- mem_out_data changes only on read completion or timeout, and holds across stores and idle cycles.
- Upstream holds all es_* inputs stable while lsu_stall = 1. Changes to es_* in BUSY are ignored because the access is latched.
- dram_ready outside BUSY is ignored.
- Back-to-back accesses: the next op is seen in IDLE, the cycle after DONE.

Test Plan:
- LB, addr 0x1003, dram_rdata 0x80FF_1234, ready on first BUSY cycle → stall high 2 cycles, dram_addr 0x1000, mem_out_data 0xFFFF_FF80, dram_we 0.
- LHU, addr 0x2002, rdata 0xBEEF_0000, ready delayed 5 cycles → stall high 6 cycles, dram_req held, mem_out_data 0x0000_BEEF.
- SB, addr 0x3001, rs2 0x1234_56AB → dram_wstrb 0010, dram_wdata 0xABAB_ABAB, dram_we 1; mem_out_data unchanged from the previous load.
- LW, addr 0x4002 → lsu_exc 1 same cycle, lsu_stall 0, dram_req never asserted. SW with funct3 100 → lsu_exc 1.
- LW, dram_ready never asserted, TIMEOUT = 4 → exactly 4 BUSY cycles, bus_err pulse 1 cycle, mem_out_data 0, then IDLE.
- rst_n low during the 2nd BUSY cycle → dram_req 0 asynchronously, all outputs at reset values; after release a fresh LW completes normally.
